dmem_arbiter: RTL and testbench

Shares the single-port data memory between the MIPS core and one external requester (loader/debug port), so the bench or a boot loader can read and write DMEM while the processor runs. Sits between `mips`, the external port and `DMEM` in the top level. The core gets fixed priority, bounded by a starvation counter. The external side uses a req/ack handshake. The core sees a same-cycle stall.

---
 rtl/mips_pkg.sv | 18 +
 rtl/dmem_arbiter.sv | 97 +++++++++
 tb/tb_dmem_arbiter.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared types and default widths for the MIPS data-memory path.
// Owner encoding records which requester used DMEM in the previous cycle.
package mips_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    OWN_IDLE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_EXT  = 2'd2
  } owner_e;

  function automatic int burst_cnt_width(input int max_burst);
    return (max_burst < 1) ? 1 : $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/dmem_arbiter.sv
// Single-port DMEM arbiter: MIPS core has priority, the external req/ack port
// is guaranteed a slot after at most MAX_BURST consecutive core grants.
//
// state (last_owner) | meaning
// OWN_IDLE           | nothing accessed DMEM last cycle
// OWN_CORE           | core load/store used DMEM last cycle
// OWN_EXT            | external access used DMEM last cycle (ext_ack now high)
module dmem_arbiter
  import mips_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_stall,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              ext_ack,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int BW = burst_cnt_width(MAX_BURST);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

  logic [BW-1:0] burst_cnt;
  owner_e        last_owner;
  logic          ext_v;
  logic          burst_full;
  logic          grant_ext;
  logic          grant_core;

  // The ack cycle masks the still-held request so one request is one access.
  always_comb begin
    ext_v      = ext_req & ~ext_ack;
    burst_full = (burst_cnt == BURST_MAX);
    grant_ext  = ext_v & (~core_req | burst_full);
    grant_core = core_req & ~grant_ext;
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = core_addr;
    mem_wdata = core_wdata;
    if (grant_ext) begin
      mem_we    = ext_we;
      mem_addr  = ext_addr;
      mem_wdata = ext_wdata;
    end else if (grant_core) begin
      mem_we = core_we;
    end
  end

  assign core_rdata = mem_rdata;
  assign core_stall = core_req & ~grant_core;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ext_ack    <= 1'b0;
      ext_rdata  <= '0;
      burst_cnt  <= '0;
      last_owner <= OWN_IDLE;
    end else begin
      ext_ack <= grant_ext;
      if (grant_ext) begin
        ext_rdata <= mem_rdata;
      end

      if (grant_ext || !ext_v) begin
        burst_cnt <= '0;
      end else if (grant_core && !burst_full) begin
        burst_cnt <= burst_cnt + BW'(1);
      end

      if (grant_ext) begin
        last_owner <= OWN_EXT;
      end else if (grant_core) begin
        last_owner <= OWN_CORE;
      end else begin
        last_owner <= OWN_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a word-addressed DMEM model that
// counts writes; each scenario task drives and checks its own vectors.
module tb_dmem_arbiter;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        core_req, core_we;
  logic [31:0] core_addr, core_wdata, core_rdata;
  logic        core_stall;
  logic        ext_req, ext_we;
  logic [31:0] ext_addr, ext_wdata, ext_rdata;
  logic        ext_ack;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [0:255];
  logic        mem_clear;
  int          wr_cnt = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(4)) dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_rdata(core_rdata), .core_stall(core_stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr),
    .ext_wdata(ext_wdata), .ext_rdata(ext_rdata), .ext_ack(ext_ack),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hA500_0000 | i;
    end else if (mem_we) begin
      mem[mem_addr[9:2]] <= mem_wdata;
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    core_req = 0; core_we = 0; core_addr = 0; core_wdata = 0;
    ext_req = 0; ext_we = 0; ext_addr = 0; ext_wdata = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1; mem_clear = 1;
    tick(); tick();
    mem_clear = 0;
    #1;
    n_checks++; if (ext_ack !== 1'b0) $display("FAIL reset_ack: got %b expected 0", ext_ack); else n_pass++;
    n_checks++; if (ext_rdata !== 32'h0) $display("FAIL reset_rdata: got %h expected 0", ext_rdata); else n_pass++;
    n_checks++; if (dut.burst_cnt !== '0) $display("FAIL reset_burst: got %0d expected 0", dut.burst_cnt); else n_pass++;
    n_checks++; if (dut.last_owner !== OWN_IDLE) $display("FAIL reset_owner: got %0d expected %0d", dut.last_owner, OWN_IDLE); else n_pass++;
    reset = 0;
    tick();
    core_req = 1; core_addr = 32'h0;
    #2;
    n_checks++; if (core_stall !== 1'b0) $display("FAIL core_alone_stall: got %b expected 0", core_stall); else n_pass++;
    n_checks++; if (core_rdata !== 32'hA500_0000) $display("FAIL core_rdata: got %h expected A5000000", core_rdata); else n_pass++;
    tick();
    n_checks++; if (dut.last_owner !== OWN_CORE) $display("FAIL owner_core: got %0d expected %0d", dut.last_owner, OWN_CORE); else n_pass++;
    idle_inputs();
    tick();
  endtask

  task automatic test_ext_write_read();
    ext_req = 1; ext_we = 1; ext_addr = 32'h40; ext_wdata = 32'hDEAD_BEEF;
    #2;
    n_checks++; if (mem_we !== 1'b1 || mem_addr !== 32'h40) $display("FAIL extw_grant: got we=%b addr=%h expected we=1 addr=40", mem_we, mem_addr); else n_pass++;
    n_checks++; if (ext_ack !== 1'b0) $display("FAIL extw_early_ack: got %b expected 0", ext_ack); else n_pass++;
    n_checks++; if (core_stall !== 1'b0) $display("FAIL extw_stall: got %b expected 0", core_stall); else n_pass++;
    tick();
    ext_req = 0;
    #1;
    n_checks++; if (ext_ack !== 1'b1) $display("FAIL extw_ack: got %b expected 1", ext_ack); else n_pass++;
    n_checks++; if (ext_rdata !== 32'hA500_0010) $display("FAIL extw_rbw: got %h expected A5000010", ext_rdata); else n_pass++;
    n_checks++; if (dut.last_owner !== OWN_EXT) $display("FAIL owner_ext: got %0d expected %0d", dut.last_owner, OWN_EXT); else n_pass++;
    tick();
    n_checks++; if (ext_ack !== 1'b0) $display("FAIL extw_ack_pulse: got %b expected 0", ext_ack); else n_pass++;
    ext_req = 1; ext_we = 0; ext_addr = 32'h40;
    tick();
    ext_req = 0;
    #1;
    n_checks++; if (ext_ack !== 1'b1) $display("FAIL extr_ack: got %b expected 1", ext_ack); else n_pass++;
    n_checks++; if (ext_rdata !== 32'hDEAD_BEEF) $display("FAIL extr_data: got %h expected DEADBEEF", ext_rdata); else n_pass++;
    idle_inputs();
    tick();
  endtask

  task automatic test_burst_fairness();
    int wr0;
    bit exp_stall, exp_ack;
    wr0 = wr_cnt;
    core_req = 1; core_we = 0; core_addr = 32'h0;
    ext_req = 1; ext_we = 0; ext_addr = 32'h44;
    // Req held across acks: the ack cycle's core grant is not counted, so period is 6.
    for (int k = 0; k < 17; k++) begin
      #2;
      exp_stall = (k == 4) || (k == 10) || (k == 16);
      exp_ack   = (k == 5) || (k == 11);
      n_checks++; if (core_stall !== exp_stall) $display("FAIL burst_stall_c%0d: got %b expected %b", k, core_stall, exp_stall); else n_pass++;
      n_checks++; if (ext_ack !== exp_ack) $display("FAIL burst_ack_c%0d: got %b expected %b", k, ext_ack, exp_ack); else n_pass++;
      if (k == 5) begin
        n_checks++; if (ext_rdata !== 32'hA500_0011) $display("FAIL burst_rdata: got %h expected A5000011", ext_rdata); else n_pass++;
      end
      tick();
    end
    idle_inputs();
    tick();
    n_checks++; if (wr_cnt - wr0 !== 0) $display("FAIL burst_no_writes: got %0d expected 0", wr_cnt - wr0); else n_pass++;
  endtask

  task automatic test_collision();
    core_req = 1; core_we = 1; core_addr = 32'h80; core_wdata = 32'h11;
    ext_req = 1; ext_we = 1; ext_addr = 32'h80; ext_wdata = 32'h22;
    #2;
    n_checks++; if (mem_wdata !== 32'h11 || core_stall !== 1'b0) $display("FAIL coll_core_first: got wdata=%h stall=%b expected 11/0", mem_wdata, core_stall); else n_pass++;
    tick();
    core_we = 0; core_addr = 32'h0;
    n_checks++; if (mem[32] !== 32'h11) $display("FAIL coll_core_stored: got %h expected 11", mem[32]); else n_pass++;
    tick(); tick(); tick();
    #1;
    n_checks++; if (core_stall !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 32'h22 || mem_addr !== 32'h80)
      $display("FAIL coll_ext_grant: got stall=%b we=%b wdata=%h addr=%h expected 1/1/22/80", core_stall, mem_we, mem_wdata, mem_addr);
    else n_pass++;
    tick();
    ext_req = 0;
    #1;
    n_checks++; if (ext_ack !== 1'b1 || ext_rdata !== 32'h11) $display("FAIL coll_ack: got ack=%b rdata=%h expected 1/11", ext_ack, ext_rdata); else n_pass++;
    idle_inputs();
    tick();
    n_checks++; if (mem[32] !== 32'h22) $display("FAIL coll_final: got %h expected 22", mem[32]); else n_pass++;
  endtask

  task automatic test_hold_across_ack();
    int wr0;
    wr0 = wr_cnt;
    ext_req = 1; ext_we = 1; ext_addr = 32'h48; ext_wdata = 32'h55;
    tick();
    #1;
    n_checks++; if (mem_we !== 1'b0) $display("FAIL hold_no_regrant: got %b expected 0", mem_we); else n_pass++;
    tick();
    ext_req = 0;
    #1;
    n_checks++; if (wr_cnt - wr0 !== 1) $display("FAIL hold_write_count: got %0d expected 1", wr_cnt - wr0); else n_pass++;
    n_checks++; if (ext_ack !== 1'b0) $display("FAIL hold_single_ack: got %b expected 0", ext_ack); else n_pass++;
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid();
    ext_req = 1; ext_we = 0; ext_addr = 32'h40;
    tick();
    ext_req = 0;
    n_checks++; if (ext_ack !== 1'b1) $display("FAIL rstmid_pre_ack: got %b expected 1", ext_ack); else n_pass++;
    reset = 1;
    #1;
    n_checks++; if (ext_ack !== 1'b0) $display("FAIL rstmid_ack: got %b expected 0", ext_ack); else n_pass++;
    n_checks++; if (dut.burst_cnt !== '0) $display("FAIL rstmid_burst: got %0d expected 0", dut.burst_cnt); else n_pass++;
    tick();
    reset = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++; if (ext_ack !== 1'b0) $display("FAIL rstmid_no_ack_c%0d: got %b expected 0", k, ext_ack); else n_pass++;
    end
  endtask

  task automatic test_abandon();
    int wr0;
    wr0 = wr_cnt;
    core_req = 1; core_we = 0; core_addr = 32'h0;
    tick();
    ext_req = 1; ext_we = 1; ext_addr = 32'h40; ext_wdata = 32'h99;
    #2;
    n_checks++; if (core_stall !== 1'b0 || mem_we !== 1'b0) $display("FAIL abandon_grant: got stall=%b we=%b expected 0/0", core_stall, mem_we); else n_pass++;
    tick();
    ext_req = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++; if (ext_ack !== 1'b0) $display("FAIL abandon_ack_c%0d: got %b expected 0", k, ext_ack); else n_pass++;
      tick();
    end
    idle_inputs();
    tick();
    n_checks++; if (mem[16] !== 32'hDEAD_BEEF || wr_cnt != wr0) $display("FAIL abandon_mem: got %h writes=%0d expected DEADBEEF writes=0", mem[16], wr_cnt - wr0); else n_pass++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_ext_write_read();
    test_burst_fairness();
    test_collision();
    test_hold_across_ack();
    test_reset_mid();
    test_abandon();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
